// File: rtl/red_shared_reduction_scheduler.sv
// red_shared_reduction_scheduler
// Shares one reduction datapath between two requesters. The owner is picked
// round-robin, its reduction type is held stable for the whole job, and its
// input words are streamed from coefficient memory into the datapath.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no job; requests sampled and arbitrated here only
// FEED  | issuing coefficients, one start strobe every GAP cycles
// WAIT  | all coefficients issued; waiting for red_done or timeout
// DONE  | one-cycle done pulse to the owner; grant released after it

module red_shared_reduction_scheduler #(
    parameter int N_COEFF = 64,
    parameter int WORDS   = 2,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          type0,
    input  logic          type1,
    input  logic [10:0]   base0,
    input  logic [10:0]   base1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [6:0]    result_cnt,
    output logic          mem_en,
    output logic [10:0]   mem_addr,
    input  logic [117:0]  mem_rdata,
    input  logic          mem_sign,
    output logic          red_type,
    output logic [117:0]  red_data,
    output logic          red_data_ready,
    output logic          red_sign,
    output logic          red_start_new,
    input  logic          red_result_write,
    input  logic          red_done
);

    localparam int C_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int K_W = (N_COEFF > 1) ? $clog2(N_COEFF) : 1;
    localparam int T_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [C_W-1:0] C_LAST    = C_W'(GAP - 1);
    localparam logic [C_W-1:0] C_WORDS   = C_W'(WORDS);
    localparam logic [K_W-1:0] K_LAST    = K_W'(N_COEFF - 1);
    localparam logic [T_W-1:0] T_LOAD    = T_W'(TIMEOUT);
    localparam logic [10:0]    ADDR_STEP = 11'(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           owner;
    logic           last_owner;
    logic           type_q;
    logic [10:0]    coef_addr;
    logic [C_W-1:0] c_cnt;
    logic [K_W-1:0] k_cnt;
    logic [T_W-1:0] tmr;
    logic           err_q;
    logic [6:0]     cnt_q;

    logic           grant_now;
    logic           grant_sel;
    logic           feed_last;
    logic           tmo_hit;

    // With both requesting, the one not served last wins; otherwise whoever asks.
    assign grant_now = (state == IDLE) && (req0 || req1);
    assign grant_sel = (req0 && req1) ? ~last_owner : req1;
    assign feed_last = (state == FEED) && (c_cnt == C_LAST) && (k_cnt == K_LAST);
    // red_done in the same cycle as expiry counts as a normal completion.
    assign tmo_hit   = (state == WAIT) && !red_done && (tmr == '0);

    assign red_type   = type_q;
    assign result_cnt = cnt_q;
    assign err        = err_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req0 || req1) state_nxt = FEED;
            FEED: if (feed_last) state_nxt = WAIT;
            WAIT: if (red_done || (tmr == '0)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job context: owner, latched type/base, coefficient and word counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            type_q     <= 1'b0;
            coef_addr  <= '0;
            c_cnt      <= '0;
            k_cnt      <= '0;
        end else begin
            if (grant_now) begin
                owner     <= grant_sel;
                type_q    <= grant_sel ? type1 : type0;
                coef_addr <= grant_sel ? base1 : base0;
                c_cnt     <= '0;
                k_cnt     <= '0;
            end else if (state == FEED) begin
                if (c_cnt == C_LAST) begin
                    c_cnt     <= '0;
                    k_cnt     <= k_cnt + 1'b1;
                    coef_addr <= coef_addr + ADDR_STEP;
                end else begin
                    c_cnt <= c_cnt + 1'b1;
                end
            end
            if (state == DONE) begin
                last_owner <= owner;
            end
        end
    end

    // WAIT timeout: down-counter loaded on entry, expires at terminal count 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr   <= '0;
            err_q <= 1'b0;
        end else begin
            if (feed_last) begin
                tmr <= T_LOAD;
            end else if ((state == WAIT) && (tmr != '0)) begin
                tmr <= tmr - 1'b1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    // Result-write counter, saturating, only while a job is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (grant_now) begin
            cnt_q <= '0;
        end else if ((state != IDLE) && red_result_write && (cnt_q != 7'h7F)) begin
            cnt_q <= cnt_q + 7'd1;
        end
    end

    // One-register alignment of memory read data into the datapath.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            red_data       <= '0;
            red_sign       <= 1'b0;
            red_data_ready <= 1'b0;
        end else begin
            red_data       <= mem_rdata;
            red_sign       <= mem_sign;
            red_data_ready <= mem_en;
        end
    end

    // Decoded outputs: grants, done pulses, memory reads and start strobe.
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        done0         = 1'b0;
        done1         = 1'b0;
        mem_en        = 1'b0;
        mem_addr      = '0;
        red_start_new = 1'b0;
        if (state != IDLE) begin
            gnt0 = ~owner;
            gnt1 = owner;
        end
        if (state == DONE) begin
            done0 = ~owner;
            done1 = owner;
        end
        if (state == FEED) begin
            red_start_new = (c_cnt == '0);
            if (c_cnt < C_WORDS) begin
                mem_en   = 1'b1;
                mem_addr = coef_addr + 11'(c_cnt);
            end
        end
    end

endmodule

// File: tb/tb_red_shared_reduction_scheduler.sv
// Bench for red_shared_reduction_scheduler: table of jobs on a small instance
// (N_COEFF=4, WORDS=2, GAP=4, TIMEOUT=15) plus hand-written reset, address
// wrap and counter saturation sequences (second instance, TIMEOUT=255).

module tb_red_shared_reduction_scheduler;

    localparam int N_A = 4;
    localparam int W_A = 2;
    localparam int G_A = 4;
    localparam int T_A = 15;
    localparam int N_B = 2;
    localparam int W_B = 2;
    localparam int G_B = 4;
    localparam int T_B = 255;

    logic          clk;
    logic          rst;

    logic          req0, req1, type0, type1;
    logic [10:0]   base0, base1;
    logic          gnt0, gnt1, done0, done1, err;
    logic [6:0]    result_cnt;
    logic          mem_en;
    logic [10:0]   mem_addr;
    logic [117:0]  mem_rdata;
    logic          mem_sign;
    logic          red_type;
    logic [117:0]  red_data;
    logic          red_data_ready, red_sign, red_start_new;
    logic          red_result_write, red_done;

    logic          b_req0, b_req1, b_type0, b_type1;
    logic [10:0]   b_base0, b_base1;
    logic          b_gnt0, b_gnt1, b_done0, b_done1, b_err;
    logic [6:0]    b_result_cnt;
    logic          b_mem_en;
    logic [10:0]   b_mem_addr;
    logic [117:0]  b_mem_rdata;
    logic          b_mem_sign;
    logic          b_red_type;
    logic [117:0]  b_red_data;
    logic          b_red_data_ready, b_red_sign, b_red_start_new;
    logic          b_red_result_write, b_red_done;

    int n_cmp = 0;
    int n_mis = 0;
    logic exp_err = 1'b0;

    typedef struct {
        logic [117:0] d;
        logic         s;
        logic         v;
    } pipe_t;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        t0;
        logic        t1;
        logic [10:0] b0;
        logic [10:0] b1;
        logic        exp_who;
        int          n_writes;
        int          early_done;
        int          drop_at;
        int          done_delay;
    } job_t;

    pipe_t       pipe_q[$];
    logic [10:0] addr_q[$];
    job_t        jobs[5];

    red_shared_reduction_scheduler #(
        .N_COEFF(N_A), .WORDS(W_A), .GAP(G_A), .TIMEOUT(T_A)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .type0(type0), .type1(type1),
        .base0(base0), .base1(base1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .result_cnt(result_cnt), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_sign(mem_sign), .red_type(red_type),
        .red_data(red_data), .red_data_ready(red_data_ready), .red_sign(red_sign),
        .red_start_new(red_start_new), .red_result_write(red_result_write),
        .red_done(red_done)
    );

    red_shared_reduction_scheduler #(
        .N_COEFF(N_B), .WORDS(W_B), .GAP(G_B), .TIMEOUT(T_B)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .req1(b_req1), .type0(b_type0), .type1(b_type1),
        .base0(b_base0), .base1(b_base1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .err(b_err),
        .result_cnt(b_result_cnt), .mem_en(b_mem_en), .mem_addr(b_mem_addr),
        .mem_rdata(b_mem_rdata), .mem_sign(b_mem_sign), .red_type(b_red_type),
        .red_data(b_red_data), .red_data_ready(b_red_data_ready), .red_sign(b_red_sign),
        .red_start_new(b_red_start_new), .red_result_write(b_red_result_write),
        .red_done(b_red_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory-side driver and scoreboards for the small instance.
    initial begin
        logic [127:0] rd;
        pipe_t        p;
        logic [10:0]  ea;
        mem_rdata = '0;
        mem_sign  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pipe_q.delete();
                addr_q.delete();
            end else begin
                if (pipe_q.size() > 0) begin
                    p = pipe_q.pop_front();
                    chk("red_data_ready", red_data_ready, p.v);
                    chk("red_data", red_data, p.d);
                    chk("red_sign", red_sign, p.s);
                end
                if (mem_en) begin
                    if (addr_q.size() == 0) begin
                        chk("mem_addr_unexpected_read", 1'b1, 1'b0);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("mem_addr", mem_addr, ea);
                    end
                end
                rd = {$urandom, $urandom, $urandom, $urandom};
                mem_rdata = rd[117:0];
                mem_sign  = 1'($urandom_range(0, 1));
                p.d = mem_rdata;
                p.s = mem_sign;
                p.v = mem_en;
                pipe_q.push_back(p);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Runs one job on the small instance, starting at a negedge in IDLE and
    // returning at the negedge of the first IDLE cycle after the done pulse.
    task automatic run_job(input job_t v);
        logic        who;
        logic        own_gnt;
        logic [10:0] b;
        int          lim;
        int          exp_cnt;
        who = v.exp_who;
        b   = who ? v.b1 : v.b0;
        for (int k = 0; k < N_A; k++) begin
            for (int c = 0; c < W_A; c++) begin
                addr_q.push_back(b + 11'(k * W_A + c));
            end
        end
        req0 = v.r0; req1 = v.r1;
        type0 = v.t0; type1 = v.t1;
        base0 = v.b0; base1 = v.b1;
        @(negedge clk);
        chk("grant_gnt0", gnt0, !who);
        chk("grant_gnt1", gnt1, who);
        chk("grant_red_type", red_type, who ? v.t1 : v.t0);
        chk("grant_result_cnt_cleared", result_cnt, 7'd0);
        for (int i = 0; i < N_A * G_A; i++) begin
            own_gnt = who ? gnt1 : gnt0;
            chk("feed_gnt", own_gnt, 1'b1);
            chk("feed_no_overlap", gnt0 & gnt1, 1'b0);
            chk("feed_start_new", red_start_new, (i % G_A) == 0);
            chk("feed_mem_en", mem_en, (i % G_A) < W_A);
            chk("feed_red_type", red_type, who ? v.t1 : v.t0);
            red_result_write = (i < v.n_writes);
            red_done = (i == v.early_done);
            if (i == v.drop_at) begin
                if (who) req1 = 1'b0;
                else     req0 = 1'b0;
            end
            @(negedge clk);
        end
        red_result_write = 1'b0;
        red_done = 1'b0;
        lim = (v.done_delay >= 0) ? v.done_delay : T_A;
        for (int j = 0; j <= lim; j++) begin
            own_gnt = who ? gnt1 : gnt0;
            chk("wait_gnt", own_gnt, 1'b1);
            chk("wait_no_done", done0 | done1, 1'b0);
            chk("wait_no_start", red_start_new | mem_en, 1'b0);
            chk("wait_err", err, exp_err);
            red_done = (j == v.done_delay);
            @(negedge clk);
        end
        red_done = 1'b0;
        if (v.done_delay < 0) exp_err = 1'b1;
        exp_cnt = (v.n_writes > 127) ? 127 : v.n_writes;
        chk("done0", done0, !who);
        chk("done1", done1, who);
        chk("done_gnt_held", who ? gnt1 : gnt0, 1'b1);
        chk("done_err", err, exp_err);
        chk("done_result_cnt", result_cnt, 7'(exp_cnt));
        if (who) req1 = 1'b0;
        else     req0 = 1'b0;
        @(negedge clk);
        chk("idle_gnt", {gnt0, gnt1}, 2'b00);
        chk("idle_done", {done0, done1}, 2'b00);
    endtask

    initial begin
        logic [10:0] got_b[4];
        int          n_addr;

        jobs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 11'h100, 11'h200, 1'b0, 10, -1, -1, 2};
        jobs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 11'h100, 11'h200, 1'b1, 0, 5, -1, 0};
        jobs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 11'h7FC, 11'h200, 1'b0, 16, -1, 3, 15};
        jobs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 11'h7FC, 11'h7FE, 1'b1, 3, -1, -1, -1};
        jobs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 11'h000, 11'h7FE, 1'b0, 1, -1, -1, 4};

        rst = 1'b0;
        req0 = 0; req1 = 0; type0 = 0; type1 = 0; base0 = '0; base1 = '0;
        red_result_write = 0; red_done = 0;
        b_req0 = 0; b_req1 = 0; b_type0 = 0; b_type1 = 0; b_base0 = '0; b_base1 = '0;
        b_mem_rdata = '0; b_mem_sign = 0; b_red_result_write = 0; b_red_done = 0;

        repeat (3) @(negedge clk);
        chk("rst_gnt", {gnt0, gnt1}, 2'b00);
        chk("rst_done", {done0, done1}, 2'b00);
        chk("rst_err", err, 1'b0);
        chk("rst_result_cnt", result_cnt, 7'd0);
        chk("rst_mem", {mem_en, mem_addr}, 12'd0);
        chk("rst_red_ctl", {red_type, red_data_ready, red_sign, red_start_new}, 4'd0);
        chk("rst_red_data", red_data, 118'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_gnt", {gnt0, gnt1}, 2'b00);

        for (int n = 0; n < 5; n++) begin
            run_job(jobs[n]);
        end

        // Reset in the middle of FEED, at the start of coefficient k=2.
        req0 = 1'b1; req1 = 1'b0; type0 = 1'b1; base0 = 11'h100;
        for (int a = 0; a < N_A * W_A; a++) addr_q.push_back(11'h100 + 11'(a));
        @(negedge clk);
        repeat (2 * G_A) @(negedge clk);
        chk("pre_rst_gnt0", gnt0, 1'b1);
        chk("pre_rst_addr_k2", mem_addr, 11'h104);
        chk("pre_rst_err", err, 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_gnt", {gnt0, gnt1}, 2'b00);
        chk("midrst_done", {done0, done1}, 2'b00);
        chk("midrst_err", err, 1'b0);
        chk("midrst_result_cnt", result_cnt, 7'd0);
        chk("midrst_mem", {mem_en, mem_addr}, 12'd0);
        chk("midrst_red_ctl", {red_type, red_data_ready, red_start_new}, 3'd0);
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_ready", red_data_ready, 1'b0);
        rst = 1'b1;
        run_job('{1'b1, 1'b0, 1'b1, 1'b0, 11'h100, 11'h000, 1'b0, 2, -1, -1, 1});

        // Result writes outside a grant are ignored.
        red_result_write = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_write_ignored", result_cnt, 7'd2);
        chk("idle_write_no_gnt", {gnt0, gnt1}, 2'b00);
        red_result_write = 1'b0;

        // Wide instance: 11-bit address wrap and result counter saturation.
        b_type1 = 1'b1; b_base1 = 11'h7FE; b_req1 = 1'b1;
        @(negedge clk);
        chk("b_gnt1", b_gnt1, 1'b1);
        chk("b_gnt0", b_gnt0, 1'b0);
        chk("b_red_type", b_red_type, 1'b1);
        n_addr = 0;
        for (int i = 0; i < 220; i++) begin
            if (b_mem_en) begin
                if (n_addr < 4) got_b[n_addr] = b_mem_addr;
                n_addr++;
            end
            if (i == 126) chk("b_cnt_126", b_result_cnt, 7'd126);
            if (i == 150) chk("b_cnt_sat_150", b_result_cnt, 7'd127);
            b_red_result_write = (i < 200);
            @(negedge clk);
        end
        b_red_result_write = 1'b0;
        chk("b_gnt1_held", b_gnt1, 1'b1);
        chk("b_read_count", 32'(n_addr), 32'd4);
        chk("b_addr0", got_b[0], 11'h7FE);
        chk("b_addr1", got_b[1], 11'h7FF);
        chk("b_addr2", got_b[2], 11'h000);
        chk("b_addr3", got_b[3], 11'h001);
        b_red_done = 1'b1;
        @(negedge clk);
        b_red_done = 1'b0;
        chk("b_done1", b_done1, 1'b1);
        chk("b_done0", b_done0, 1'b0);
        chk("b_err", b_err, 1'b0);
        chk("b_cnt_final", b_result_cnt, 7'd127);
        b_req1 = 1'b0;
        @(negedge clk);
        chk("b_idle_gnt", {b_gnt0, b_gnt1, b_done1}, 3'd0);

        chk("addr_queue_drained", 32'(addr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/red_shared_reduction_scheduler.md
# red_shared_reduction_scheduler

Scheduler and arbiter that shares one 180-bit-q-then-30-bit-qi reduction datapath between two requesters, for example the lift and scale paths. It grants a requester round-robin and holds the reduction type stable for the whole job. It streams that requester's 118-bit input words from coefficient memory into the datapath, pulses the per-coefficient start strobe, counts result writes, and returns a per-requester done pulse when the datapath reports completion, or when a timeout expires.

## Interface
Parameters:
- N_COEFF, 64, coefficients per job
- WORDS, 2, 118-bit input words per coefficient (1..7)
- GAP, 4, cycles between successive coefficient starts; must satisfy GAP ≥ WORDS+1
- TIMEOUT, 1023, maximum cycles in WAIT before the job is aborted

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-low
- req0, req1  in  1  job request, level, held until matching done pulse
- type0, type1  in  1  reduction_type for that requester's job
- base0, base1  in  11  memory base address of that requester's job
- gnt0, gnt1  out  1  grant, high for the entire job
- done0, done1  out  1  one-cycle job-complete pulse
- err  out  1  sticky timeout flag, cleared only by reset
- result_cnt  out  7  result writes counted in current/last job
- mem_en  out  1  memory read strobe
- mem_addr  out  11  memory read address
- mem_rdata  in  118  read data, valid 1 cycle after mem_en
- mem_sign  in  1  coefficient sign, valid with mem_rdata
- red_type  out  1  reduction_type to datapath
- red_data  out  118  input word to datapath
- red_data_ready  out  1  red_data valid strobe
- red_sign  out  1  sign_large_red_in to datapath
- red_start_new  out  1  div_start_new strobe, one per coefficient
- red_result_write  in  1  datapath result-write strobe
- red_done  in  1  datapath done pulse

## Operation
States: IDLE, FEED, WAIT, DONE.

IDLE
- Requests are sampled only here.
- If exactly one req is high, grant it.
- If both are high, grant the requester not granted last. After reset, req0 wins.
- On grant, latch type and base, clear result_cnt, set coefficient index k=0 and in-coefficient counter c=0, assert gnt, go FEED.

FEED
- c counts 0..GAP-1 and wraps; k increments on wrap.
- red_start_new = 1 when c==0.
- mem_en = 1 when c<WORDS, with mem_addr = base + k·WORDS + c (mod 2048; wrap is legal).
- After c==GAP-1 with k==N_COEFF-1, go WAIT.

WAIT
- A timer counts from 0.
- red_done → DONE.
- Timer == TIMEOUT → set err, go DONE.

DONE
- Pulse the granted done for one cycle, drop gnt, record the last-granted requester, go IDLE.

Datapath feed
- Data path: red_data, red_sign and red_data_ready are mem_rdata, mem_sign and mem_en delayed by exactly one register.
- red_type equals the latched type whenever gnt is high; it holds its last value otherwise.
- result_cnt increments on every red_result_write while gnt is high, saturating at 127.
- red_result_write outside a grant is ignored.
- red_done outside WAIT is ignored.
- A req dropped mid-job does not abort the job; done still pulses.

## Timing
- Reset values: all outputs are 0, state = IDLE, last-granted = req1, so req0 wins first.
- Grant latency: req high in IDLE at cycle t → gnt high at t+1, with the first red_start_new and mem_en (c=0) at t+1.
- First red_data_ready appears at t+2.
- Coefficient k starts at t+1+k·GAP.
- FEED lasts N_COEFF·GAP cycles.
- WAIT begins at t+1+N_COEFF·GAP.
- If red_done arrives at cycle d in WAIT, done pulses at d+1 and gnt falls after d+1.
- IDLE is back at d+2, and a new grant can occur at d+3.
- If red_done coincides with timer == TIMEOUT, red_done wins and err is not set.
- Asserting rst mid-job immediately forces IDLE, clears gnt and err, and suppresses done.
- No red_data_ready is emitted after reset, even if a read was in flight.

## Test plan
- N_COEFF=4, WORDS=2, GAP=4: req0 with type0=1, base0=0x100 → gnt0 next cycle; mem_addr sequence 0x100..0x107, two per coefficient at c=0,1; red_start_new four times, 4 cycles apart; red_type=1 throughout; red_done in WAIT → one-cycle done0.
- req0 and req1 rise together, both held → first job granted to req0, second to req1 with no overlap of gnt0/gnt1; repeated for three jobs → alternating 0,1,0.
- base1=0x7FE, N_COEFF=2, WORDS=2 → mem_addr 0x7FE, 0x7FF, 0x000, 0x001.
- 10 red_result_write pulses during a job → result_cnt = 10; 200 pulses → result_cnt = 127.
- TIMEOUT=15 with no red_done → err=1 exactly 15 cycles into WAIT, done pulses, next job proceeds with err still 1.
- rst low during FEED at k=2 → all outputs 0 on the same edge; after release, req0 restarts its job from k=0.
